adder_32_reg: RTL and testbench

- 32-bit two's-complement adder; output registered.
- Adds a 32-bit operand A to a 30-bit operand B that is implicitly left-shifted by 2 (B[0] aligns with sum bit 2).
- Serves as the final carry-propagate adder after the Booth radix-4 / Wallace-tree compression in the 16x16 multiplier.
- In system use, the low two bits of the shifted operand are zero. They are not carried on the port.

---
 rtl/adder_32_reg_if.sv | 15 +
 rtl/adder_32_reg.sv | 102 ++++++++++
 tb/tb_adder_32_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/adder_32_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_32_reg_if
// Brief    : Operand/result bundle for the registered 32-bit final adder.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_32_reg_if;
    logic [31:0] A;
    logic [29:0] B;
    logic [31:0] C;

    modport master (output A, output B, input C);
    modport slave  (input A, input B, output C);
endinterface
`default_nettype wire

// File: rtl/adder_32_reg.sv
`default_nettype none
// ============================================================================
// Module   : adder_32_reg
// Brief    : Registered C = A + {B, 2'b00}, two-level 4-bit-group CLA.
// Revision : 1.0 - initial release
// ============================================================================
module adder_32_reg (
    input  wire logic      clk,
    input  wire logic      rst,
    adder_32_reg_if.slave  bus
);

    localparam int c_UW  = 30;
    localparam int c_GW  = 4;
    localparam int c_NG  = (c_UW + c_GW - 1) / c_GW;

    // Carry out of the low n positions in flattened sum-of-products form.
    function automatic logic f_lookahead(
        input logic [7:0] g,
        input logic [7:0] p,
        input logic       cin,
        input int         n
    );
        logic c;
        logic t;
        c = cin;
        for (int k = 0; k < 8; k++) begin
            if (k < n) c = c & p[k];
        end
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                t = g[k];
                for (int m = 0; m < 8; m++) begin
                    if (m > k && m < n) t = t & p[m];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

    logic [c_UW-1:0] w_g;
    logic [c_UW-1:0] w_p;
    logic [c_UW-1:0] w_sum_hi;
    logic [c_NG-1:0] w_grp_g;
    logic [c_NG-1:0] w_grp_p;
    logic [c_NG-1:0] w_grp_c;
    logic [31:0]     r_c;

    assign w_g = bus.A[31:2] & bus.B;
    assign w_p = bus.A[31:2] ^ bus.B;

    generate
        for (genvar j = 0; j < c_NG; j++) begin : g_grp
            localparam int c_LO = j * c_GW;
            localparam int c_W  = (c_UW - c_LO < c_GW) ? (c_UW - c_LO) : c_GW;

            logic [7:0]     w_gv;
            logic [7:0]     w_pv;
            logic [c_W-1:0] w_bc;

            always_comb begin
                w_gv = '0;
                w_pv = '0;
                w_gv[c_W-1:0] = w_g[c_LO +: c_W];
                w_pv[c_W-1:0] = w_p[c_LO +: c_W];
            end

            assign w_grp_g[j] = f_lookahead(w_gv, w_pv, 1'b0, c_W);
            assign w_grp_p[j] = &w_pv[c_W-1:0];

            always_comb begin
                w_bc = '0;
                for (int i = 0; i < c_W; i++) begin
                    w_bc[i] = f_lookahead(w_gv, w_pv, w_grp_c[j], i);
                end
            end

            assign w_sum_hi[c_LO +: c_W] = w_pv[c_W-1:0] ^ w_bc;
        end
    endgenerate

    // Second-level lookahead: every group carry-in directly from group G/P.
    always_comb begin
        w_grp_c = '0;
        for (int j = 0; j < c_NG; j++) begin
            w_grp_c[j] = f_lookahead(8'(w_grp_g), 8'(w_grp_p), 1'b0, j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= 32'h0000_0000;
        end else begin
            r_c <= {w_sum_hi, bus.A[1:0]};
        end
    end

    assign bus.C = r_c;

endmodule
`default_nettype wire

// File: tb/tb_adder_32_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_32_reg
// Brief    : Scoreboard bench for adder_32_reg against A + {B, 2'b00}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_32_reg;

    logic clk;
    logic rst;
    adder_32_reg_if bus ();

    adder_32_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    logic [31:0] q_exp[$];

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one operand pair, push its expected result, then compare after the edge.
    task automatic t_vec(input string tag, input logic r, input logic [31:0] a, input logic [29:0] b);
        logic [31:0] exp;
        rst   = r;
        bus.A = a;
        bus.B = b;
        q_exp.push_back(r ? 32'h0 : a + {b, 2'b00});
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            t_check({tag, "_empty"}, bus.C, 32'hDEAD_BEEF);
        end else begin
            exp = q_exp.pop_front();
            t_check(tag, bus.C, exp);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [29:0] b;
        n_checks = 0;
        n_pass   = 0;
        rst   = 1'b1;
        bus.A = 32'h0;
        bus.B = 30'h0;
        @(posedge clk);
        #1;

        t_vec("reset_hold",  1'b1, 32'h1234_5678, 30'h3FFF_FFFF);
        t_vec("reset_hold2", 1'b1, 32'h1234_5678, 30'h3FFF_FFFF);
        t_vec("first_valid", 1'b0, 32'h1234_5678, 30'h3FFF_FFFF);
        t_vec("low_pass",    1'b0, 32'h0000_0003, 30'h0000_0000);
        t_vec("low_all1",    1'b0, 32'h0000_0003, 30'h3FFF_FFFF);
        t_vec("wrap_zero",   1'b0, 32'hFFFF_FFFC, 30'h0000_0001);
        t_vec("carry_msb",   1'b0, 32'h7FFF_FFFC, 30'h0000_0001);
        t_vec("signed_mix",  1'b0, 32'hFFFF_FFF0, 30'h0000_0005);
        t_vec("midreset",    1'b1, 32'hAAAA_AAAA, 30'h1555_5555);
        t_vec("after_rst",   1'b0, 32'h0000_00FF, 30'h0000_0040);

        for (int i = 0; i < 101; i++) begin
            a = $urandom;
            b = 30'($urandom);
            b[2] = 1'b0;
            b[6] = 1'b0;
            t_vec("rand_con", 1'b0, a, b);
        end

        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = 30'($urandom);
            t_vec("rand_free", 1'b0, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
